lcd_bus_receiver: RTL

Responder end of the 8-bit 8080-style LCD write bus (db, wr, d_c, reset) that the screen controller drives toward the Arduino-shield LCD. The block decodes the ILI9341-style command stream and emits one pixel-write event per received RGB565 pixel, with its screen coordinates. It is used to mirror LCD traffic into a VGA frame buffer and as a synthesizable bus checker in the on-board self-test.

---
 rtl/lcd_bus_receiver.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: responder for an 8-bit 8080-style LCD write bus.
// Decodes the ILI9341-style command stream (CASET/PASET/RAMWR/SWRESET) and
// emits one pixel event per received RGB565 pixel, with its window coordinates.
//
// Ports:
//   clk, resetN             system clock, async active-low reset
//   lcd_db[7:0], lcd_wr     bus byte and write strobe (byte taken on wr rise)
//   lcd_d_c                 0 = command, 1 = data/parameter
//   lcd_reset               bus reset, active-low, behaves like SWRESET
//   cmd_valid, cmd_code     command pulse and last command byte
//   pxl_valid, pxl_x/y      pixel pulse and its coordinates
//   pxl_rgb565, pxl_rgb12   raw pixel and its 4:4:4 reduction
//   frame_done              pixel at (EC, EP) wraps the window
//   protocol_err            rejected CASET/PASET parameter set
module lcd_bus_receiver #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  lcd_db,
    input  logic        lcd_wr,
    input  logic        lcd_d_c,
    input  logic        lcd_reset,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        pxl_valid,
    output logic [15:0] pxl_x,
    output logic [15:0] pxl_y,
    output logic [15:0] pxl_rgb565,
    output logic [11:0] pxl_rgb12,
    output logic        frame_done,
    output logic        protocol_err
);

    localparam logic [15:0] EC_DEF = 16'(WIDTH - 1);
    localparam logic [15:0] EP_DEF = 16'(HEIGHT - 1);

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_PASET,
        ST_RAMWR_HI,
        ST_RAMWR_LO,
        ST_IGNORE
    } state_t;

    // Two-flop synchronizers plus a third wr stage for rise detection
    logic [7:0] db_s1, db_s2;
    logic       dc_s1, dc_s2;
    logic       wr_s1, wr_s2, wr_s3;
    logic       rst_s1, rst_s2;

    // Registered byte event: sets the 3-clk strobe-to-output latency
    logic       ev_valid;
    logic [7:0] ev_db;
    logic       ev_dc;

    state_t      state;
    logic [1:0]  idx;
    logic [15:0] p_start;
    logic [7:0]  p_end_hi;
    logic [7:0]  hi_byte;
    logic [15:0] sc, ec, sp, ep;
    logic [15:0] cur_x, cur_y;

    logic [15:0] new_end;
    logic        win_ok;

    // Synchronizer chain
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            db_s1  <= '0;
            db_s2  <= '0;
            dc_s1  <= 1'b0;
            dc_s2  <= 1'b0;
            wr_s1  <= 1'b0;
            wr_s2  <= 1'b0;
            wr_s3  <= 1'b0;
            rst_s1 <= 1'b0;
            rst_s2 <= 1'b0;
        end else begin
            db_s1  <= lcd_db;
            db_s2  <= db_s1;
            dc_s1  <= lcd_d_c;
            dc_s2  <= dc_s1;
            wr_s1  <= lcd_wr;
            wr_s2  <= wr_s1;
            wr_s3  <= wr_s2;
            rst_s1 <= lcd_reset;
            rst_s2 <= rst_s1;
        end
    end

    // Byte event capture; strobes seen while the bus is held in reset are dropped
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ev_valid <= 1'b0;
            ev_db    <= '0;
            ev_dc    <= 1'b0;
        end else begin
            ev_valid <= wr_s2 & ~wr_s3 & rst_s2;
            ev_db    <= db_s2;
            ev_dc    <= dc_s2;
        end
    end

    // Window check on the 4th CASET/PASET parameter byte
    always_comb begin
        new_end = {p_end_hi, ev_db};
        win_ok  = 1'b0;
        if (p_start <= new_end) begin
            if (state == ST_CASET) begin
                win_ok = 32'(new_end) < WIDTH;
            end else begin
                win_ok = 32'(new_end) < HEIGHT;
            end
        end
    end

    // Command decoder, window registers, cursor and output registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= ST_IDLE;
            idx          <= '0;
            p_start      <= '0;
            p_end_hi     <= '0;
            hi_byte      <= '0;
            sc           <= '0;
            ec           <= EC_DEF;
            sp           <= '0;
            ep           <= EP_DEF;
            cur_x        <= '0;
            cur_y        <= '0;
            cmd_valid    <= 1'b0;
            cmd_code     <= '0;
            pxl_valid    <= 1'b0;
            pxl_x        <= '0;
            pxl_y        <= '0;
            pxl_rgb565   <= '0;
            pxl_rgb12    <= '0;
            frame_done   <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            cmd_valid    <= 1'b0;
            pxl_valid    <= 1'b0;
            frame_done   <= 1'b0;
            protocol_err <= 1'b0;

            if (!rst_s2) begin
                // Bus reset: same effect as SWRESET, held while low
                state <= ST_IDLE;
                idx   <= '0;
                sc    <= '0;
                ec    <= EC_DEF;
                sp    <= '0;
                ep    <= EP_DEF;
            end else if (ev_valid) begin
                if (!ev_dc) begin
                    cmd_valid <= 1'b1;
                    cmd_code  <= ev_db;
                    idx       <= '0;
                    case (ev_db)
                        CMD_CASET: state <= ST_CASET;
                        CMD_PASET: state <= ST_PASET;
                        CMD_RAMWR: begin
                            state <= ST_RAMWR_HI;
                            cur_x <= sc;
                            cur_y <= sp;
                        end
                        CMD_SWRESET: begin
                            state <= ST_IDLE;
                            sc    <= '0;
                            ec    <= EC_DEF;
                            sp    <= '0;
                            ep    <= EP_DEF;
                        end
                        default: state <= ST_IGNORE;
                    endcase
                end else begin
                    case (state)
                        ST_CASET, ST_PASET: begin
                            idx <= idx + 2'd1;
                            case (idx)
                                2'd0: p_start[15:8] <= ev_db;
                                2'd1: p_start[7:0]  <= ev_db;
                                2'd2: p_end_hi      <= ev_db;
                                default: begin
                                    if (win_ok) begin
                                        if (state == ST_CASET) begin
                                            sc <= p_start;
                                            ec <= new_end;
                                        end else begin
                                            sp <= p_start;
                                            ep <= new_end;
                                        end
                                    end else begin
                                        protocol_err <= 1'b1;
                                    end
                                    state <= ST_IGNORE;
                                end
                            endcase
                        end
                        ST_RAMWR_HI: begin
                            hi_byte <= ev_db;
                            state   <= ST_RAMWR_LO;
                        end
                        ST_RAMWR_LO: begin
                            pxl_valid  <= 1'b1;
                            pxl_x      <= cur_x;
                            pxl_y      <= cur_y;
                            pxl_rgb565 <= {hi_byte, ev_db};
                            // {R[15:12], G[10:7], B[4:1]}
                            pxl_rgb12  <= {hi_byte[7:4], hi_byte[2:0], ev_db[7], ev_db[4:1]};
                            if (cur_x == ec) begin
                                cur_x <= sc;
                                if (cur_y == ep) begin
                                    cur_y      <= sp;
                                    frame_done <= 1'b1;
                                end else begin
                                    cur_y <= cur_y + 16'd1;
                                end
                            end else begin
                                cur_x <= cur_x + 16'd1;
                            end
                            state <= ST_RAMWR_HI;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
